// File: rtl/camera_capture.sv
// camera_capture: CMOS camera byte-stream capture (RGB565, high byte first)
// into 16-bit pixel writes toward an async FIFO.
// Optional build macro: CAPTURE_TEST_PATTERN_EN replaces captured pixel data
// with colour bars selected by pixel_x[9:7]; timing, gating and overflow are unchanged.
module camera_capture #(
  parameter int unsigned H_ACTIVE       = 640,
  parameter int unsigned V_ACTIVE       = 480,
  parameter int unsigned STARTUP_FRAMES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmos_vsync,
  input  logic        cmos_href,
  input  logic [7:0]  cmos_data,
  input  logic        full_fifo,
  output logic        wr_en,
  output logic [15:0] dout,
  output logic [11:0] pixel_x,
  output logic [11:0] pixel_y,
  output logic        frame_done,
  output logic        overflow
);

  localparam int unsigned XY_W   = 12;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned PIX_W  = 16;
  localparam int unsigned CNT_W  = (STARTUP_FRAMES < 2) ? 1 : $clog2(STARTUP_FRAMES + 1);
  localparam logic [XY_W-1:0] XY_MAX = '1;

`ifdef CAPTURE_TEST_PATTERN_EN
  localparam bit TEST_PATTERN = 1'b1;
`else
  localparam bit TEST_PATTERN = 1'b0;
`endif

  typedef enum logic [1:0] {
    STARTUP = 2'd0,
    WAIT_VS = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t            state, state_d;
  logic              vs_q, hr_q;
  logic              phase, phase_d;
  logic [BYTE_W-1:0] hi, hi_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [XY_W-1:0]   x_d, y_d;
  logic [PIX_W-1:0]  dout_d;
  logic              wr_en_d, frame_done_d, overflow_d;
  logic              vs_rise, vs_fall, hr_fall;
  logic              in_window;

  // Colour-bar value for a given bar index.
  function automatic logic [PIX_W-1:0] bar_color(input logic [2:0] bar);
    logic [PIX_W-1:0] c;
    case (bar)
      3'd0:    c = 16'hF800;
      3'd1:    c = 16'h07E0;
      3'd2:    c = 16'h001F;
      3'd3:    c = 16'hFFFF;
      3'd4:    c = 16'h0000;
      3'd5:    c = 16'hFFE0;
      3'd6:    c = 16'h07FF;
      default: c = 16'hF81F;
    endcase
    return c;
  endfunction

  // Sync-signal edges against the one-stage registered copies.
  assign vs_rise = cmos_vsync & ~vs_q;
  assign vs_fall = ~cmos_vsync & vs_q;
  assign hr_fall = ~cmos_href & hr_q;

  // Active window check for the pixel completing this cycle.
  assign in_window = (32'(pixel_x) < H_ACTIVE) && (32'(pixel_y) < V_ACTIVE);

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    phase_d      = phase;
    hi_d         = hi;
    x_d          = pixel_x;
    y_d          = pixel_y;
    wr_en_d      = 1'b0;
    dout_d       = dout;
    frame_done_d = 1'b0;
    overflow_d   = overflow;

    case (state)
      STARTUP: begin
        if (STARTUP_FRAMES == 0) begin
          state_d = WAIT_VS;
        end else if (vs_rise) begin
          cnt_d = cnt + CNT_W'(1);
          if (32'(cnt) + 32'd1 >= STARTUP_FRAMES) begin
            state_d = WAIT_VS;
          end
        end
      end

      WAIT_VS: begin
        if (vs_fall) begin
          state_d = CAPTURE;
          x_d     = '0;
          y_d     = '0;
          phase_d = 1'b0;
        end
      end

      CAPTURE: begin
        if (vs_rise) begin
          // End of frame wins over any byte on the bus; partial pixel dropped.
          frame_done_d = 1'b1;
          phase_d      = 1'b0;
          state_d      = WAIT_VS;
        end else if (hr_fall) begin
          x_d     = '0;
          phase_d = 1'b0;
          y_d     = (pixel_y == XY_MAX) ? pixel_y : pixel_y + XY_W'(1);
        end else if (cmos_href) begin
          if (!phase) begin
            hi_d    = cmos_data;
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (in_window) begin
              if (full_fifo) begin
                overflow_d = 1'b1;
              end else begin
                wr_en_d = 1'b1;
                dout_d  = TEST_PATTERN ? bar_color(pixel_x[9:7]) : {hi, cmos_data};
              end
            end
            x_d = (pixel_x == XY_MAX) ? pixel_x : pixel_x + XY_W'(1);
          end
        end
      end

      default: begin
        state_d = STARTUP;
      end
    endcase
  end

  // State, counters and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= STARTUP;
      vs_q       <= 1'b0;
      hr_q       <= 1'b0;
      phase      <= 1'b0;
      hi         <= '0;
      cnt        <= '0;
      pixel_x    <= '0;
      pixel_y    <= '0;
      wr_en      <= 1'b0;
      dout       <= '0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_d;
      vs_q       <= cmos_vsync;
      hr_q       <= cmos_href;
      phase      <= phase_d;
      hi         <= hi_d;
      cnt        <= cnt_d;
      pixel_x    <= x_d;
      pixel_y    <= y_d;
      wr_en      <= wr_en_d;
      dout       <= dout_d;
      frame_done <= frame_done_d;
      overflow   <= overflow_d;
    end
  end

endmodule

// File: tb/tb_camera_capture.sv
// Testbench for camera_capture: scaled-down frames (16x8 active), scoreboard of
// expected pixel writes checked as the DUT emits wr_en.
module tb_camera_capture;

  localparam int H = 16;
  localparam int V = 8;

`ifdef CAPTURE_TEST_PATTERN_EN
  localparam bit PAT = 1'b1;
`else
  localparam bit PAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        vs;
  logic        hr;
  logic [7:0]  data;
  logic        full;
  logic        wr_en;
  logic [15:0] dout;
  logic [11:0] pixel_x;
  logic [11:0] pixel_y;
  logic        frame_done;
  logic        overflow;

  int          checks   = 0;
  int          failures = 0;
  int          writes   = 0;
  int          fd_count = 0;
  logic        fd_prev  = 1'b0;
  logic [15:0] exp_q[$];
  int          mx, my;
  bit          exp_ovf;
  logic [15:0] val;

  always #5 clk = ~clk;

  camera_capture #(
    .H_ACTIVE      (H),
    .V_ACTIVE      (V),
    .STARTUP_FRAMES(1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmos_vsync(vs),
    .cmos_href (hr),
    .cmos_data (data),
    .full_fifo (full),
    .wr_en     (wr_en),
    .dout      (dout),
    .pixel_x   (pixel_x),
    .pixel_y   (pixel_y),
    .frame_done(frame_done),
    .overflow  (overflow)
  );

  // Expected written value for camera value v at column x.
  function automatic logic [15:0] expect_pix(input logic [15:0] v, input int x);
    logic [2:0]  bar;
    logic [15:0] c;
    bar = 3'((x >> 7) & 7);
    case (bar)
      3'd0:    c = 16'hF800;
      3'd1:    c = 16'h07E0;
      3'd2:    c = 16'h001F;
      3'd3:    c = 16'hFFFF;
      3'd4:    c = 16'h0000;
      3'd5:    c = 16'hFFE0;
      3'd6:    c = 16'h07FF;
      default: c = 16'hF81F;
    endcase
    return PAT ? c : v;
  endfunction

  // Output monitor: pops the scoreboard on each write, tracks frame_done pulses.
  always @(negedge clk) begin
    logic [15:0] e;
    if (frame_done === 1'b1) begin
      fd_count++;
      checks++;
      if (fd_prev === 1'b1) begin
        failures++;
        $display("FAIL frame_done_width: high for 2+ cycles, required 1");
      end
    end
    fd_prev = frame_done;
    if (wr_en === 1'b1) begin
      writes++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write: dout=%h, required no write", dout);
      end else begin
        e = exp_q.pop_front();
        if (dout !== e) begin
          failures++;
          $display("FAIL write_data: dout=%h required %h", dout, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One line of npix pixels, optional trailing odd byte, optional full at pixel full_idx.
  task automatic send_line(input int npix, input bit odd, input bit cap,
                           input int full_idx, input bit fixed);
    logic [15:0] v;
    for (int p = 0; p < npix; p++) begin
      v    = fixed ? 16'h1234 : val;
      hr   = 1'b1;
      full = 1'b0;
      data = v[15:8];
      step();
      data = v[7:0];
      full = (p == full_idx);
      if (cap && mx < H && my < V) begin
        if (full) exp_ovf = 1'b1;
        else exp_q.push_back(expect_pix(v, mx));
      end
      step();
      if (cap && mx < 4095) mx++;
      val++;
    end
    full = 1'b0;
    if (odd) begin
      hr   = 1'b1;
      data = 8'hAB;
      step();
    end
    if (cap) begin
      checks++;
      if (pixel_x !== 12'(mx)) begin
        failures++;
        $display("FAIL line_end_x: pixel_x=%0d required %0d", pixel_x, mx);
      end
    end
    hr   = 1'b0;
    data = 8'h00;
    step();
    if (cap) begin
      mx = 0;
      if (my < 4095) my++;
      checks++;
      if (pixel_y !== 12'(my) || pixel_x !== 12'd0) begin
        failures++;
        $display("FAIL line_advance: pixel_x=%0d pixel_y=%0d required 0 %0d",
                 pixel_x, pixel_y, my);
      end
    end
    step();
  endtask

  task automatic begin_frame();
    mx  = 0;
    my  = 0;
    val = 16'h0000;
  endtask

  // Vsync pulse closing the frame, then frame-level checks.
  task automatic end_frame(input bit cap, input int fd0);
    vs = 1'b1;
    step();
    step();
    step();
    vs = 1'b0;
    step();
    step();
    checks++;
    if (fd_count - fd0 !== (cap ? 1 : 0)) begin
      failures++;
      $display("FAIL frame_done_count: got %0d required %0d", fd_count - fd0, cap ? 1 : 0);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_writes: %0d pending, required 0", exp_q.size());
      exp_q.delete();
    end
    checks++;
    if (overflow !== exp_ovf) begin
      failures++;
      $display("FAIL overflow_flag: overflow=%b required %b", overflow, exp_ovf);
    end
  endtask

  task automatic send_frame(input int nlines, input int npix, input bit cap,
                            input bit fixed, input int full_line, input int full_idx);
    int fd0;
    fd0 = fd_count;
    begin_frame();
    for (int l = 0; l < nlines; l++) begin
      send_line(npix, 1'b0, cap, (l == full_line) ? full_idx : -1, fixed);
    end
    end_frame(cap, fd0);
  endtask

  task automatic check_zero_outputs(input string tag);
    checks++;
    if (wr_en !== 1'b0 || dout !== 16'h0 || pixel_x !== 12'd0 || pixel_y !== 12'd0 ||
        frame_done !== 1'b0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL %s: wr_en=%b dout=%h x=%0d y=%0d fd=%b ovf=%b, required all 0",
               tag, wr_en, dout, pixel_x, pixel_y, frame_done, overflow);
    end
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    vs   = 1'b0;
    hr   = 1'b0;
    data = 8'h00;
    full = 1'b0;
    exp_ovf = 1'b0;
    step();
    step();
    check_zero_outputs("reset_outputs");
    rst = 1'b0;
    step();
    check_zero_outputs("post_reset_idle");
  endtask

  task automatic test_startup_frame();
    int w0;
    w0 = writes;
    send_frame(V, H, 1'b0, 1'b1, -1, -1);
    checks++;
    if (writes != w0) begin
      failures++;
      $display("FAIL startup_discard: writes=%0d required 0", writes - w0);
    end
  endtask

  task automatic test_full_frame();
    int w0;
    w0 = writes;
    send_frame(V, H, 1'b1, 1'b0, -1, -1);
    checks++;
    if (writes - w0 != H * V) begin
      failures++;
      $display("FAIL frame_writes: writes=%0d required %0d", writes - w0, H * V);
    end
  endtask

  task automatic test_long_lines();
    int w0;
    w0 = writes;
    send_frame(V + 2, H + 4, 1'b1, 1'b0, -1, -1);
    checks++;
    if (writes - w0 != H * V) begin
      failures++;
      $display("FAIL window_writes: writes=%0d required %0d", writes - w0, H * V);
    end
  endtask

  task automatic test_overflow();
    send_frame(V, H, 1'b1, 1'b0, 0, 5);
    checks++;
    if (overflow !== 1'b1) begin
      failures++;
      $display("FAIL overflow_set: overflow=%b required 1", overflow);
    end
    send_frame(2, 4, 1'b1, 1'b0, -1, -1);
  endtask

  task automatic test_odd_bytes();
    int fd0;
    int w0;
    fd0 = fd_count;
    w0  = writes;
    begin_frame();
    send_line(1, 1'b1, 1'b1, -1, 1'b0);
    send_line(4, 1'b0, 1'b1, -1, 1'b0);
    end_frame(1'b1, fd0);
    checks++;
    if (writes - w0 != 5) begin
      failures++;
      $display("FAIL odd_byte_writes: writes=%0d required 5", writes - w0);
    end
  endtask

  task automatic test_reset_mid_frame();
    int fd0;
    fd0 = fd_count;
    begin_frame();
    send_line(3, 1'b0, 1'b1, -1, 1'b0);
    hr   = 1'b1;
    data = val[15:8];
    step();
    data = val[7:0];
    exp_q.push_back(expect_pix(val, mx));
    step();
    mx++;
    val++;
    data = 8'hAA;
    step();
    rst  = 1'b1;
    data = 8'hBB;
    step();
    check_zero_outputs("mid_frame_reset");
    rst     = 1'b0;
    hr      = 1'b0;
    data    = 8'h00;
    exp_ovf = 1'b0;
    step();
    step();
    checks++;
    if (fd_count != fd0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL reset_abort: frame_done=%0d pending=%0d, required 0 0",
               fd_count - fd0, exp_q.size());
    end
    test_startup_frame();
    test_full_frame();
  endtask

  initial begin
    test_reset();
    test_startup_frame();
    test_full_frame();
    test_long_lines();
    test_overflow();
    test_odd_bytes();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/camera_capture.md
CAMERA_CAPTURE -- requirements
Module: camera_capture

Interface
REQ-001 Parameter H_ACTIVE, default 640: pixels captured per line; later pixels in the line are dropped.
REQ-002 Parameter V_ACTIVE, default 480: lines captured per frame; later lines are dropped.
REQ-003 Parameter STARTUP_FRAMES, default 1: whole frames discarded after reset while the camera settles.
REQ-004 clk  in  1  camera pixel clock (PCLK domain); all logic is clocked on its rising edge.
REQ-005 rst  in  1  synchronous reset, active-high.
REQ-006 cmos_vsync  in  1  camera VSYNC, high during vertical blanking; synchronous to clk.
REQ-007 cmos_href  in  1  camera HREF, high while line bytes are valid.
REQ-008 cmos_data  in  8  camera byte bus, RGB565, high byte first.
REQ-009 full_fifo  in  1  async FIFO write-side full flag.
REQ-010 wr_en  out  1  FIFO write strobe, one cycle per pixel.
REQ-011 dout  out  16  pixel {hi,lo} RGB565, valid when wr_en=1.
REQ-012 pixel_x  out  12  pixel index within the current line.
REQ-013 pixel_y  out  12  line index within the current frame.
REQ-014 frame_done  out  1  one-cycle pulse at the end of each captured frame.
REQ-015 overflow  out  1  sticky flag: a pixel was dropped because the FIFO was full.

Function
REQ-016 The block SHALL register cmos_vsync and cmos_href one stage (vs_q, hr_q) for edge detection; edges are current value vs registered value.
REQ-017 States SHALL be STARTUP, WAIT_VS and CAPTURE; reset enters STARTUP.
REQ-018 STARTUP: count vsync rising edges; on the STARTUP_FRAMES-th rising edge go to WAIT_VS (STARTUP_FRAMES=0 goes to WAIT_VS on the first cycle after reset).
REQ-019 WAIT_VS: on a vsync falling edge go to CAPTURE and clear pixel_x, pixel_y and the byte phase.
REQ-020 CAPTURE, href=1: phase 0 latches cmos_data as hi and sets phase 1; phase 1 forms {hi,cmos_data} and clears phase 0.
REQ-021 Output timing: dout and wr_en SHALL be registered, so wr_en=1 in the cycle after the lo byte is sampled, for exactly one cycle.
REQ-022 A pixel SHALL be written only if pixel_x<H_ACTIVE, pixel_y<V_ACTIVE and full_fifo=0 in the cycle the lo byte is sampled.
REQ-023 A pixel that qualifies except for full_fifo=1 SHALL be dropped, with overflow set to 1.
REQ-024 pixel_x SHALL increment on every completed pixel (written or dropped) and saturate at 4095.
REQ-025 On an href falling edge in CAPTURE: pixel_x=0, phase=0, pixel_y increments (saturating at 4095); a pending hi byte is discarded.
REQ-026 On a vsync rising edge in CAPTURE: pulse frame_done for one cycle, then go to WAIT_VS; any partial pixel is discarded.
REQ-027 If the vsync rising edge coincides with href=1, the vsync rule wins and no byte is latched in that cycle.
REQ-028 wr_en SHALL never be asserted outside CAPTURE.
REQ-029 overflow SHALL stay set until reset.

Reset
REQ-030 In any cycle with rst=1: state=STARTUP and wr_en=0, dout=0, pixel_x=0, pixel_y=0, frame_done=0, overflow=0, phase=0, startup count=0, vs_q=0, hr_q=0.
REQ-031 A reset asserted mid-frame SHALL abort the frame with no frame_done pulse; after reset, capture restarts at STARTUP.

Configuration
REQ-032 With CAPTURE_TEST_PATTERN_EN defined, every written pixel's dout SHALL be a colour-bar value selected by pixel_x[9:7]: 0=F800, 1=07E0, 2=001F, 3=FFFF, 4=0000, 5=FFE0, 6=07FF, 7=F81F.
REQ-033 With CAPTURE_TEST_PATTERN_EN defined, all timing, gating and overflow behaviour SHALL remain unchanged, and the value of cmos_data SHALL be ignored.
REQ-034 Without CAPTURE_TEST_PATTERN_EN, dout SHALL be the camera data per REQ-020.

Verification
REQ-035 Reset, then one full frame of 640x480 with bytes 0x12,0x34 -> zero wr_en pulses (startup frame discarded), overflow=0.
REQ-036 Second frame, 640x480, pixel n bytes {n[15:8], n[7:0]} -> 307200 wr_en pulses in order, dout=n, one frame_done after vsync rises.
REQ-037 Line of 700 pixels -> 640 writes, pixel_x ends at 700, pixel_y+1 on href fall; frame of 490 lines -> no writes for lines 480-489.
REQ-038 full_fifo=1 during pixel 5 of line 0 -> pixel 5 not written, overflow=1 and held; pixel 6 is written with pixel_x correct.
REQ-039 href falls after an odd byte (3 bytes) -> 1 write; the next line starts at phase 0 with correct pairing.
REQ-040 rst=1 for one cycle mid-line -> all outputs 0 next cycle, no frame_done, and the next full frame is discarded per STARTUP.
